// File: rtl/truth_table_capture.sv
// Exhaustive 4-input response analyser: sweeps vec 0..15, samples f at the end of each hold, checks the table.
// Optional first-mismatch reporting (err_valid/first_err) is compiled in with `define TT_FIRST_ERR_EN.
module truth_table_capture #(
    parameter int          HOLD_CYCLES = 20,
    parameter logic [15:0] EXPECTED    = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [3:0]  vec,
    input  logic        f,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] table_out
`ifdef TT_FIRST_ERR_EN
    ,
    output logic        err_valid,
    output logic [3:0]  first_err
`endif
);

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

    // HOLD_CYCLES=256 maps to 255, so the 8-bit counter wraps cleanly at the last hold clock.
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] cnt;
    logic       accept;
    logic       sample;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        sample    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt == HOLD_LAST) begin
                    sample = 1'b1;
                    if (vec == 4'd15) state_nxt = CHECK;
                end
            end
            CHECK:   state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vec       <= 4'd0;
            cnt       <= 8'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            table_out <= 16'd0;
        end else begin
            if (accept) begin
                vec       <= 4'd0;
                cnt       <= 8'd0;
                busy      <= 1'b1;
                done      <= 1'b0;
                pass      <= 1'b0;
                table_out <= 16'd0;
            end
            if (state == DRIVE) begin
                if (sample) begin
                    table_out[vec] <= f;
                    cnt            <= 8'd0;
                    // 15 -> 0 wrap coincides with the move into CHECK
                    vec            <= vec + 4'd1;
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end
            if (state == CHECK) begin
                pass <= (table_out == EXPECTED);
                done <= 1'b1;
                busy <= 1'b0;
            end
        end
    end

`ifdef TT_FIRST_ERR_EN
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            err_valid <= 1'b0;
            first_err <= 4'd0;
        end else if (sample && (f != EXPECTED[vec]) && !err_valid) begin
            err_valid <= 1'b1;
            first_err <= vec;
        end
    end
`endif

endmodule

// File: doc/truth_table_capture.md
# truth_table_capture

Self-checking response analyser for 4-input combinational lab circuits. It sweeps the 16 input vectors {a,b,c,d} into a device under test, holds each one for a programmable number of clocks, and samples the DUT output f at the end of each hold. It assembles the 16 samples into a truth-table word and compares that word against an expected constant. It is the response end of our exhaustive-stimulus benches and lets a lab circuit be checked in hardware or simulation without a manual waveform review.

## Interface

- HOLD_CYCLES, 20, clocks each vector is held; legal range 1..256
- EXPECTED, 16'h0000, expected truth table; bit i is the required f for vector i
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a sweep; sampled only in IDLE or DONE
- vec  output  4  vector to DUT; vec[3]=a, vec[2]=b, vec[1]=c, vec[0]=d
- f  input  1  DUT response; combinational function of vec
- busy  output  1  high while sweeping or checking
- done  output  1  high in DONE until the next accepted start or reset
- pass  output  1  valid while done=1; 1 when table_out==EXPECTED
- table_out  output  16  captured truth table; bit i = f sampled while vec==i
- err_valid  output  1  only with TT_FIRST_ERR_EN; a mismatch has been seen in this sweep
- first_err  output  4  only with TT_FIRST_ERR_EN; index of the first mismatching vector

## Operation

- States: IDLE, DRIVE, CHECK, DONE. Internal hold counter cnt is 8 bits wide.
- Reset: state=IDLE, vec=0, cnt=0, busy=0, done=0, pass=0, table_out=0, err_valid=0, first_err=0. Reset has priority at any point, including mid-sweep. Reset discards the partial table.
- IDLE or DONE with start=1: go to DRIVE. Set vec=0, cnt=0, busy=1, done=0, pass=0, table_out=0, err_valid=0, first_err=0.
- DRIVE, each edge:
  - If cnt==HOLD_CYCLES-1: table_out[vec] <= f and cnt <= 0.
    - If vec==15: go to CHECK and set vec <= 0.
    - Otherwise: vec <= vec+1.
  - Otherwise: cnt <= cnt+1.
- CHECK, one cycle: pass <= (table_out==EXPECTED), done <= 1, busy <= 0. Go to DONE.
- DONE: outputs hold their values. vec=0.
- start while busy=1 is ignored. It is neither queued nor does it restart the sweep.
- A start held high in DONE restarts the sweep on the next edge.

## Timing

- Let E0 be the edge at which start is accepted.
- Vector k is driven from E0+k·HOLD_CYCLES through E0+(k+1)·HOLD_CYCLES.
- f for vector k is sampled at edge E0+(k+1)·HOLD_CYCLES, the last edge of that hold.
- CHECK is entered at E0+16·HOLD_CYCLES.
- done=1 and pass are valid after E0+16·HOLD_CYCLES+1. Total latency is 16·HOLD_CYCLES+1 clocks.
- HOLD_CYCLES=1: each vector lasts one clock, and f is sampled in the same cycle the vector is applied.
- HOLD_CYCLES=256: cnt reaches 255 and wraps to 0. There is no overflow.
- vec wraps from 15 to 0 only on the transition into CHECK.

## Configuration

- Macro TT_FIRST_ERR_EN.
- Defined:
  - err_valid and first_err ports exist.
  - At each sample edge in DRIVE, if f != EXPECTED[vec] and err_valid==0, then first_err <= vec and err_valid <= 1.
  - Later mismatches do not change these outputs.
  - Both are cleared on reset and on an accepted start.
- Undefined:
  - Both ports and their logic are absent.
  - Pass/fail is reported only through pass in DONE.

## Test plan

- XOR4 DUT, EXPECTED=16'h6996, HOLD_CYCLES=20, pulse start -> done after 321 clocks, table_out=16'h6996, pass=1, err_valid=0.
- AND4 DUT (f=1 only at vec=15), EXPECTED=16'h6996 -> table_out=16'h8000, pass=0; with macro, first_err=1, err_valid=1.
- HOLD_CYCLES=1, XOR4 DUT, start at E0 -> vec steps 0..15 on consecutive clocks, done=1 after E0+17, pass=1.
- Assert rst at vec=7 mid-hold -> next cycle state IDLE, vec=0, busy=0, table_out=0. A fresh start then completes normally with pass=1.
- Pulse start again at vec=5 during the sweep -> no effect; done still arrives at the original cycle.
- Hold start high through DONE -> sweep restarts the next edge with done=0, pass=0, table_out=0, and the second result is identical to the first.
